// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud-rate constants and frame helpers
// used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int SYS_CLK_HZ           = 50_000_000;
  localparam int BAUD_RATE            = 115_200;
  localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / BAUD_RATE;
  // The receiver samples each bit at its centre, half a bit after the edge.
  localparam int RX_SAMPLE_OFFSET     = DEFAULT_CLKS_PER_BIT / 2;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic int frame_cycles(input int cpb, input int data_bits,
                                      input int parity_en, input int stop_bits);
    return cpb * (1 + data_bits + parity_en + stop_bits) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level valid/ready handshake between the fabric-side producer and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of every bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte on a valid/ready handshake and serialises it
// as start, LSB-first data, optional parity and 1 or 2 stop bits on tx_pin.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      tx_busy,
  output logic      tx_done,
  output logic      tx_pin
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic PAR_INV   = (PARITY_ODD != 0);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_ready;
  logic                 r_pin;

  logic w_tick;
  logic w_clear;
  logic w_accept;

  // Holding the counter clear throughout IDLE guarantees START begins at count 0.
  assign w_clear  = (r_state == ST_IDLE);
  assign w_accept = r_ready && bus.tx_valid;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Data path: the byte is captured at the handshake, so later tx_data changes are ignored.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift  <= bus.tx_data;
      r_parity <= calc_parity(8'(bus.tx_data), PAR_INV);
    end else if ((r_state == ST_DATA) && w_tick) begin
      r_shift  <= r_shift >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pin      <= 1'b1;
      r_ready    <= 1'b1;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_pin <= 1'b1;
          if (w_accept) begin
            r_state    <= ST_START;
            r_pin      <= 1'b0;
            r_ready    <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_pin   <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                r_state <= ST_PARITY;
                r_pin   <= r_parity;
              end else begin
                r_state <= ST_STOP;
                r_pin   <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              // The shift register advances on this same edge, so bit 1 is the next one out.
              r_pin     <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_pin   <= 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_stop_idx == LAST_STOP) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pin   <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_ready = r_ready;
  assign tx_busy      = ~r_ready;
  assign tx_pin       = r_pin;
  // Decoded from flops only; high on the last cycle of the final stop bit.
  assign tx_done      = (r_state == ST_STOP) && (r_stop_idx == LAST_STOP) && w_tick;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized bench for uart_tx with four parameterisations at CLKS_PER_BIT=4.
module tb_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] v;
  logic [7:0] dat [4];
  logic [1:0] sel;

  uart_tx_if #(.DATA_BITS(8)) bus_a ();
  uart_tx_if #(.DATA_BITS(8)) bus_b ();
  uart_tx_if #(.DATA_BITS(8)) bus_c ();
  uart_tx_if #(.DATA_BITS(8)) bus_d ();

  assign bus_a.tx_valid = v[0];
  assign bus_a.tx_data  = dat[0];
  assign bus_b.tx_valid = v[1];
  assign bus_b.tx_data  = dat[1];
  assign bus_c.tx_valid = v[2];
  assign bus_c.tx_data  = dat[2];
  assign bus_d.tx_valid = v[3];
  assign bus_d.tx_data  = dat[3];

  logic pin_a, pin_b, pin_c, pin_d;
  logic busy_a, busy_b, busy_c, busy_d;
  logic done_a, done_b, done_c, done_d;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a), .tx_busy(busy_a), .tx_done(done_a), .tx_pin(pin_a));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b), .tx_busy(busy_b), .tx_done(done_b), .tx_pin(pin_b));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c), .tx_busy(busy_c), .tx_done(done_c), .tx_pin(pin_c));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
    .clk(clk), .rst(rst), .bus(bus_d), .tx_busy(busy_d), .tx_done(done_d), .tx_pin(pin_d));

  logic [3:0] pin_v, rdy_v, busy_v, done_v;
  assign pin_v  = {pin_d, pin_c, pin_b, pin_a};
  assign rdy_v  = {bus_d.tx_ready, bus_c.tx_ready, bus_b.tx_ready, bus_a.tx_ready};
  assign busy_v = {busy_d, busy_c, busy_b, busy_a};
  assign done_v = {done_d, done_c, done_b, done_a};

  logic pin_s, rdy_s, busy_s, done_s;
  assign pin_s  = pin_v[sel];
  assign rdy_s  = rdy_v[sel];
  assign busy_s = busy_v[sel];
  assign done_s = done_v[sel];

  logic cap_pin  [0:255];
  logic cap_rdy  [0:255];
  logic cap_busy [0:255];
  logic cap_done [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the handshake, from the frame layout alone.
  function automatic logic exp_pin(input int k, input logic [7:0] d, input int pe,
                                   input int po, input int sb);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe != 0 && b == 9) return (^d) ^ (po != 0);
    return 1'b1;
  endfunction

  function automatic int frame_len(input int pe, input int sb);
    return CPB * (1 + 8 + pe + sb);
  endfunction

  function automatic int pin_mism(input int off, input logic [7:0] d, input int pe,
                                  input int po, input int sb);
    int c;
    c = 0;
    for (int k = 1; k <= frame_len(pe, sb); k++)
      if (cap_pin[off+k] !== exp_pin(k, d, pe, po, sb)) c++;
    return c;
  endfunction

  function automatic int count_done(input int a, input int b);
    int c;
    c = 0;
    for (int k = a; k <= b; k++) if (cap_done[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_rdy(input int a, input int b);
    int c;
    c = 0;
    for (int k = a; k <= b; k++) if (cap_rdy[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_hi(input int a, input int b);
    int c;
    c = 0;
    for (int k = a; k <= b; k++) if (cap_pin[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int busy_mism(input int a, input int b);
    int c;
    c = 0;
    for (int k = a; k <= b; k++) if (cap_busy[k] !== ~cap_rdy[k]) c++;
    return c;
  endfunction

  task automatic capture(input int start, input int n);
    for (int k = start; k < start + n; k++) begin
      @(negedge clk);
      cap_pin[k]  = pin_s;
      cap_rdy[k]  = rdy_s;
      cap_busy[k] = busy_s;
      cap_done[k] = done_s;
    end
  endtask

  // Handshake one byte, then scramble tx_data so the frame must rely on the latched copy.
  task automatic send(input logic [1:0] s, input logic [7:0] d);
    sel = s;
    @(negedge clk);
    dat[s] = d;
    v[s]   = 1'b1;
    @(posedge clk);
    #1;
    v[s]   = 1'b0;
    dat[s] = 8'($urandom);
  endtask

  task automatic check_frame(input string tag, input logic [1:0] s, input logic [7:0] d,
                             input int pe, input int po, input int sb);
    int len;
    len = frame_len(pe, sb);
    send(s, d);
    capture(1, len + 1);
    check({tag, " pin"},        pin_mism(0, d, pe, po, sb), 0);
    check({tag, " done cnt"},   count_done(1, len + 1), 1);
    check({tag, " done last"},  32'(cap_done[len]), 1);
    check({tag, " rdy busy"},   32'(cap_rdy[len]), 0);
    check({tag, " rdy after"},  32'(cap_rdy[len+1]), 1);
    check({tag, " busy inv"},   busy_mism(1, len + 1), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] rx;
    int s0, rnd_pin, rnd_stop, rnd_done, rnd_frm;

    rst = 1'b1;
    v   = '0;
    sel = '0;
    for (int i = 0; i < 4; i++) dat[i] = '0;

    // Power-on reset
    @(posedge clk);
    @(negedge clk);
    check("rst pin",  32'(pin_v),  32'hF);
    check("rst rdy",  32'(rdy_v),  32'hF);
    check("rst busy", 32'(busy_v), 32'h0);
    check("rst done", 32'(done_v), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset held 3 cycles in the middle of a 0x00 frame
    send(2'd0, 8'h00);
    capture(1, 10);
    check("mid pre pin",  32'(cap_pin[10]),  0);
    check("mid pre busy", 32'(cap_busy[10]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst pin",  32'(pin_s),  1);
    check("mid rst rdy",  32'(rdy_s),  1);
    check("mid rst busy", 32'(busy_s), 0);
    check("mid rst done", 32'(done_s), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture(1, 50);
    check("mid post idle", count_hi(1, 50), 50);
    check("mid post done", count_done(1, 50), 0);

    // 8N1 frame
    check_frame("a55", 2'd0, 8'h55, 0, 0, 1);

    // Parity frames, 44 cycles each
    check_frame("b01", 2'd1, 8'h01, 1, 1, 1);
    check("b01 parity", 32'(cap_pin[38]), 0);
    check_frame("b03", 2'd1, 8'h03, 1, 1, 1);
    check("b03 parity", 32'(cap_pin[38]), 1);
    check_frame("c03", 2'd2, 8'h03, 1, 0, 1);
    check("c03 parity", 32'(cap_pin[38]), 0);

    // Back-to-back with tx_valid held high; tx_data changes right after the first handshake
    sel = 2'd0;
    @(negedge clk);
    dat[0] = 8'hA5;
    v[0]   = 1'b1;
    @(posedge clk);
    #1;
    dat[0] = 8'h3C;
    capture(1, 81);
    v[0] = 1'b0;
    capture(82, 5);
    check("b2b a5 pin",    pin_mism(0, 8'hA5, 0, 0, 1), 0);
    check("b2b 3c pin",    pin_mism(41, 8'h3C, 0, 0, 1), 0);
    check("b2b gap pin",   32'(cap_pin[41]), 1);
    check("b2b gap rdy",   count_rdy(1, 81), 1);
    check("b2b gap where", 32'(cap_rdy[41]), 1);
    check("b2b done cnt",  count_done(1, 86), 2);
    check("b2b done 1",    32'(cap_done[40]), 1);
    check("b2b done 2",    32'(cap_done[81]), 1);
    check("b2b tail idle", count_rdy(82, 86) + count_hi(82, 86), 10);

    // Reset during data bit 3 of 0xFF
    send(2'd0, 8'hFF);
    capture(1, 18);
    check("rfd pre busy", 32'(cap_busy[18]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rfd pin",  32'(pin_s),  1);
    check("rfd rdy",  32'(rdy_s),  1);
    check("rfd busy", 32'(busy_s), 0);
    capture(1, 50);
    check("rfd no done", count_done(1, 50), 0);
    check("rfd idle",    count_hi(1, 50), 50);
    check_frame("a12", 2'd0, 8'h12, 0, 0, 1);

    // 8N2: random bytes decoded by a mid-bit sampling receiver model
    rnd_pin = 0; rnd_stop = 0; rnd_done = 0; rnd_frm = 0;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      send(2'd3, d);
      capture(1, 45);
      s0 = 0;
      for (int k = 1; k <= 45; k++) if (s0 == 0 && cap_pin[k] === 1'b0) s0 = k;
      if (s0 == 0) begin
        rx = ~d;
        rnd_frm++;
      end else begin
        for (int b = 0; b < 8; b++) rx[b] = cap_pin[s0 + 2 + CPB * (b + 1)];
        if (cap_pin[s0 + 2 + CPB * 9] !== 1'b1 || cap_pin[s0 + 2 + CPB * 10] !== 1'b1) rnd_frm++;
        if (count_hi(s0 + 36, s0 + 43) != 8) rnd_stop++;
        if (cap_done[s0 + 43] !== 1'b1) rnd_done++;
      end
      check("rnd rx", 32'(rx), 32'(d));
      rnd_pin = rnd_pin + pin_mism(0, d, 0, 0, 2);
      if (count_done(1, 45) != 1) rnd_done++;
    end
    check("rnd pin",     rnd_pin, 0);
    check("rnd framing", rnd_frm, 0);
    check("rnd stop hi", rnd_stop, 0);
    check("rnd done",    rnd_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; serialises bytes from the uartController command/response logic onto tx_pin (Raspberry Pi RX side).
- Companion to the existing receive path; replaces the LOOPBACK tx_pin assignment in the top level.
- Frame format: 8N1 by default, with optional even/odd parity and 1 or 2 stop bits.
- Byte-level valid/ready handshake on the fabric side; single byte held internally, no FIFO.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal range is 2 or more
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, with PARITY_EN=1: 0 gives even parity, 1 gives odd parity
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  system clock (CLK_0 at top level)
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_BITS  byte to send; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a byte this cycle
tx_busy  output  1  frame in progress (not IDLE)
tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit
tx_pin  output  1  serial line, idles high

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - Next cycle: state=IDLE, tx_pin=1, tx_ready=1, tx_busy=0, tx_done=0, bit/baud counters=0.
  - Reset mid-frame abandons the frame; tx_pin returns high the cycle after rst is sampled.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE:
  - tx_ready=1, tx_pin=1.
  - tx_valid & tx_ready at an edge: latch tx_data into the shift register, compute the parity bit (XOR of data, inverted if PARITY_ODD), go to START.
  - Other outputs are registered: the first START cycle on tx_pin is the cycle after the handshake.
- START: tx_pin=0 for exactly CLKS_PER_BIT cycles.
- DATA:
  - LSB first; each bit is held CLKS_PER_BIT cycles.
  - Bit index counts 0..DATA_BITS-1, then leaves DATA.
- PARITY: the latched parity bit is held CLKS_PER_BIT cycles.
- STOP:
  - tx_pin=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle, then IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
  - Wraps to 0 at each bit boundary and is cleared on entry to START.
  - No fractional accumulation.
- tx_ready and tx_busy:
  - tx_ready=0 in every state except IDLE; tx_valid is ignored while busy and the byte is not consumed.
  - tx_busy = !tx_ready.
- Input stability: tx_data changes after the handshake have no effect on the frame in flight.
- Back-to-back frames:
  - With tx_valid held high, one IDLE cycle separates frames.
  - Period is CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS)+1 cycles.
- Glitch-free output: tx_pin is driven directly from a flop and has no combinational path from inputs.

Decomposition:
- Package uart_pkg holds:
  - state encoding (IDLE, START, DATA, PARITY, STOP)
  - default CLKS_PER_BIT and the baud-rate constants shared with the receiver
- One sub-module, uart_baud_tick: counter with parameter CLKS_PER_BIT and inputs clk, rst, clear; output tick high on count CLKS_PER_BIT-1.
- The receiver reuses uart_baud_tick with its mid-bit sampling offset.

Test Plan:
- Use CLKS_PER_BIT=4 throughout the plan.
- Reset check: assert rst for 3 cycles, mid-stream -> tx_pin=1, tx_ready=1, tx_busy=0, tx_done=0 on the following cycle.
- Send 0x55, 8N1 -> tx_pin sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; tx_done pulses exactly once, at cycle 40 after the handshake; tx_ready returns high the next cycle.
- Send 0x01, PARITY_EN=1, PARITY_ODD=1 -> parity bit 0; send 0x03 -> parity bit 1; PARITY_ODD=0 with 0x03 -> parity bit 0; frame is 44 cycles.
- Back-to-back 0xA5 then 0x3C, tx_valid held high:
  - both frames are correct;
  - exactly one idle-high cycle separates them;
  - tx_data changed mid-frame does not corrupt 0xA5.
- Assert rst during DATA bit 3 of 0xFF -> tx_pin=1 next cycle, no tx_done; a subsequent 0x12 frame is correct.
- STOP_BITS=2, 256 random bytes looped into the receiver model -> all bytes match; stop high time is 8 cycles.
